// File: rtl/riscv_mmio_ctrl.sv
// MMIO block for the RISCV150 core: UART byte FIFOs,
// cycle and retired-instruction counters on addr[31:28]==IO_BASE.
module riscv_mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic [7:0]    mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];
  assign cnt     = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

module riscv_mmio_ctrl #(
  parameter logic [3:0] IO_BASE    = 4'h8,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  input  logic        inst_retire,
  output logic        io_sel_q,
  output logic [31:0] io_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic          act;
  logic          rd;
  logic          wr;
  logic [5:0]    rsel;
  logic [31:0]   rdata;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ins;
  logic          cnt_clr;
  logic          ovf_clr;
  logic          tx_push;
  logic          tx_empty;
  logic          tx_full;
  logic [CW-1:0] tx_cnt;
  logic          rx_pop;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_head;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          unused;

  assign unused = ^{addr[27:8], addr[1:0], din[31:8]};

  assign hit  = (addr[31:28] == IO_BASE);
  assign act  = hit & ~stall & (re | (|we));
  assign rd   = act & re;
  assign wr   = act & (|we);
  assign rsel = addr[7:2];

  assign tx_push = wr & (rsel == 6'h02);
  assign cnt_clr = wr & (rsel == 6'h06);
  assign rx_pop  = rd & (rsel == 6'h01);
  assign ovf_clr = rd & (rsel == 6'h07);

  riscv_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (din[7:0]),
    .pop   (tx_valid & tx_ready),
    .rdata (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .cnt   (tx_cnt)
  );

  riscv_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .cnt   (rx_cnt)
  );

  assign tx_valid = ~tx_empty;

  always_comb begin
    rdata = '0;
    case (rsel)
      6'h00: rdata = {30'b0, ~rx_empty, ~tx_full};
      6'h01: rdata = {24'b0, rx_empty ? 8'h00 : rx_head};
      6'h04: rdata = 32'(cyc);
      6'h05: rdata = 32'(ins);
      6'h07: rdata = {tx_ovf, rx_ovf, 14'b0,
                      8'(tx_cnt), 8'(rx_cnt)};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_dout  <= '0;
      io_sel_q <= 1'b0;
    end else begin
      io_sel_q <= hit & ~stall;
      if (rd) io_dout <= rdata;
    end
  end

  // An overflow in the same cycle as the clearing read is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_push & tx_full)   tx_ovf <= 1'b1;
      else if (ovf_clr)        tx_ovf <= 1'b0;
      if (rx_valid & rx_full)  rx_ovf <= 1'b1;
      else if (ovf_clr)        rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | cnt_clr) begin
      cyc <= '0;
      ins <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (inst_retire & ~stall) ins <= ins + 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_mmio_ctrl.sv
// Directed bench for riscv_mmio_ctrl with scoreboard
// queues for reads, TX bytes and RX bytes.
module tb_riscv_mmio_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] din;
  logic        inst_retire;
  logic        io_sel_q;
  logic [31:0] io_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic [31:0] c1;
  logic [31:0] c2;

  always #5 clk = ~clk;

  riscv_mmio_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .addr        (addr),
    .re          (re),
    .we          (we),
    .din         (din),
    .inst_retire (inst_retire),
    .io_sel_q    (io_sel_q),
    .io_dout     (io_dout),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a,
                    input logic [31:0] exp,
                    input string tag);
    addr = {4'h8, 20'h0, a};
    re = 1'b1;
    rd_q.push_back(exp);
    tick();
    re = 1'b0;
    addr = '0;
    chk(tag, io_dout, rd_q.pop_front());
    chk({tag, "_sel"}, {31'b0, io_sel_q},
        {31'b0, ~stall});
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    addr = {4'h8, 20'h0, a};
    we = 4'hf;
    din = d;
    tick();
    we = '0;
    addr = '0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    if (tx_q.size() < 8) tx_q.push_back(b);
    wr(8'h08, {24'hABCDEF, b});
  endtask

  task automatic rx_push(input logic [7:0] b);
    if (rx_q.size() < 8) rx_q.push_back(b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic tx_drain(input string tag);
    tx_ready = 1'b1;
    while (tx_q.size() > 0) begin
      chk({tag, "_v"}, {31'b0, tx_valid}, 32'd1);
      chk({tag, "_d"}, {24'b0, tx_data},
          {24'b0, tx_q.pop_front()});
      tick();
    end
    chk({tag, "_end"}, {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    addr = '0;
    re = 1'b0;
    we = '0;
    din = '0;
    inst_retire = 1'b0;
    tx_ready = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    tick();
    tick();
    chk("rst_dout", io_dout, 32'h0);
    chk("rst_sel", {31'b0, io_sel_q}, 32'd0);
    chk("rst_txv", {31'b0, tx_valid}, 32'd0);
    rst = 1'b0;

    // 1: status and cycle counter
    rd(8'h00, 32'h1, "stat0");
    rd(8'h10, 32'd1, "cyc_first");
    addr = {4'h8, 28'h10};
    re = 1'b1;
    tick();
    re = 1'b0;
    c1 = io_dout;
    repeat (10) tick();
    addr = {4'h8, 28'h10};
    re = 1'b1;
    tick();
    re = 1'b0;
    c2 = io_dout;
    chk("cyc_delta", c2 - c1, 32'd11);

    // 2: two TX bytes
    tx_push(8'h41);
    tx_push(8'h42);
    chk("tx_v", {31'b0, tx_valid}, 32'd1);
    chk("tx_head", {24'b0, tx_data}, 32'h41);
    tx_drain("tx2");

    // 3: TX overflow
    for (int i = 0; i < 9; i++)
      tx_push(8'(8'h60 + i));
    rd(8'h1C, 32'h8000_0800, "ovf_tx");
    rd(8'h1C, 32'h0000_0800, "ovf_clr");
    tx_drain("tx9");

    // 4: RX path
    rx_push(8'h5A);
    rx_push(8'hA5);
    rd(8'h00, 32'h3, "stat_rx");
    rd(8'h04, {24'b0, rx_q.pop_front()}, "rx0");
    rd(8'h04, {24'b0, rx_q.pop_front()}, "rx1");
    rd(8'h04, 32'h0, "rx_empty");
    rd(8'h1C, 32'h0, "rx_cnt0");

    // 5: instruction counter and clear priority
    inst_retire = 1'b1;
    repeat (5) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    inst_retire = 1'b0;
    rd(8'h14, 32'd5, "ins5");
    inst_retire = 1'b1;
    wr(8'h18, 32'h0);
    inst_retire = 1'b0;
    rd(8'h10, 32'd0, "clr_cyc");
    rd(8'h14, 32'd0, "clr_ins");

    // 6: stalled read
    rx_push(8'h77);
    rd(8'h00, 32'h3, "stat_pre");
    stall = 1'b1;
    rd(8'h04, 32'h3, "stall_hold");
    stall = 1'b0;
    rd(8'h04, {24'b0, rx_q.pop_front()}, "rx_after");

    // RX overflow
    for (int i = 0; i < 9; i++)
      rx_push(8'(8'h90 + i));
    rd(8'h1C, 32'h4000_0008, "ovf_rx");
    for (int i = 0; i < 8; i++)
      rd(8'h04, {24'b0, rx_q.pop_front()}, "rx_ord");

    // Pointer wrap with push and pop in the same cycle
    rx_push(8'd3);
    for (int i = 1; i < 20; i++) begin
      rx_data = 8'(i * 7 + 3);
      rx_q.push_back(rx_data);
      rx_valid = 1'b1;
      rd(8'h04, {24'b0, rx_q.pop_front()}, "wrap");
      rx_valid = 1'b0;
    end
    rd(8'h04, {24'b0, rx_q.pop_front()}, "wrap_last");
    rd(8'h1C, 32'h0, "wrap_cnt");

    // Reset discards FIFO contents
    tx_push(8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_q.delete();
    chk("rst_mid", {31'b0, tx_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
